ddr5_rw_scheduler: RTL
======================

Name: ddr5_rw_scheduler

Overview:
- Shares the single DDR5 command path between the write-request FIFO (AXI write side) and the read-address FIFO.
- Decides whether a read or a write is issued next: reads first, write-drain watermarks, write anti-starvation.
- Inserts bus-turnaround gaps whenever direction changes.
- Sits in the mem_clk domain, after the clock-crossing FIFOs and before the CA/CS command generator.

Parameters:
- ADDR_W, 32, width of request addresses
- CNT_W, 4, width of write-FIFO occupancy count
- WR_HI_WM, 6, write count at or above which write-drain mode is forced
- WR_LO_WM, 2, write count at or below which write drain may yield to pending reads
- T_WTR, 4, idle cycles inserted on a write-to-read switch (>=1)
- T_RTW, 3, idle cycles inserted on a read-to-write switch (>=1)
- STARVE_MAX, 8, consecutive reads issued with writes pending before a write switch is forced

Ports:
- mem_clk, input, 1, scheduler clock
- rst_n, input, 1, synchronous active-low reset
- wr_empty, input, 1, write FIFO empty
- wr_count, input, CNT_W, write FIFO occupancy, including the head entry
- wr_addr, input, ADDR_W, write FIFO head address (first-word-fall-through)
- wr_pop, output, 1, one-cycle pop of write FIFO head
- rd_empty, input, 1, read-address FIFO empty
- rd_addr, input, ADDR_W, read FIFO head address (first-word-fall-through)
- rd_pop, output, 1, one-cycle pop of read FIFO head
- cmd_valid, output, 1, command slot holds a request
- cmd_write, output, 1, 1 = write, 0 = read
- cmd_addr, output, ADDR_W, command address
- cmd_ready, input, 1, command generator accepts the slot
- busy, output, 1, high whenever state is not IDLE or cmd_valid=1

Behaviour:
- **Clock and reset:** one clock, mem_clk. Reset is synchronous, active-low, on rst_n.
- **Reset values:** all outputs 0; state IDLE; last_dir=READ; starve_cnt=0; turnaround counter 0.
- **Reset mid-operation:** the slot is discarded and no pop is issued in the reset cycle. FIFO contents are untouched.
- **Slot rules:**
  - The output slot is a single register. "Slot free" = !cmd_valid, or cmd_valid && cmd_ready.
  - cmd_valid, cmd_write and cmd_addr are held stable until the handshake completes.
- **Load:**
  - In a slot-free cycle, with the chosen direction equal to last_dir, the scheduler pulses the matching pop.
  - The head address and direction are registered, so cmd_valid is high the next cycle (latency 1 from pop).
  - Back-to-back same-direction commands sustain one command per cycle while cmd_ready=1.
- **Direction choice** (evaluated only in slot-free cycles outside TURN):
  - last_dir=READ → choose WRITE if !wr_empty and any of: wr_count>=WR_HI_WM, rd_empty, starve_cnt==STARVE_MAX. Otherwise choose READ if !rd_empty.
  - last_dir=WRITE → choose READ if !rd_empty and any of: wr_empty, wr_count<=WR_LO_WM. Otherwise choose WRITE if !wr_empty.
  - Both FIFOs empty → no load; state becomes IDLE once the slot is empty.
- **States:**
  - IDLE: no request.
  - RD: issuing reads.
  - WR: issuing writes.
  - TURN: turnaround gap.
- **Turnaround:**
  - If the chosen direction differs from last_dir in decision cycle D: no pop in D; TURN covers D+1..D+T (T=T_WTR for write→read, T_RTW for read→write). cmd_valid=0 and no pops during TURN. last_dir flips at entry to TURN.
  - At D+T+1 the new direction is committed: pop if its FIFO is non-empty; otherwise go to IDLE keeping the new last_dir.
  - A new TURN may follow later under the normal rules.
- **Starvation:** starve_cnt increments on each read pop while !wr_empty, saturates at STARVE_MAX, and clears on any write pop or when wr_empty.
- **Empty/full edges:**
  - A pop never occurs when the matching empty flag is 1.
  - FIFO-full handling stays upstream; wr_count is trusted as-is.
- **Simultaneous events:** a handshake and a new load in the same cycle are legal. Direction is re-evaluated on every load.

Decomposition:
- Shared package ddr5_ctrl_pkg:
  - state encoding (IDLE/RD/WR/TURN)
  - DIR_READ=0, DIR_WRITE=1
  - default timing constants T_WTR/T_RTW
- Sub-module ddr5_turnaround_timer:
  - loadable down-counter: load value, start, done pulse after exactly T cycles
  - instantiated once.

Test Plan:
- Reset with both FIFOs non-empty: rst_n=0 for 2 cycles → no pop, cmd_valid=0, busy=0 throughout; first pop the cycle after rst_n=1.
- Single read, rd_addr=0x0000_4567, writes empty, cmd_ready=1: rd_pop at cycle N → cmd_valid=1, cmd_write=0, cmd_addr=0x0000_4567 at N+1; busy drops at N+2.
- Read then write: read 0x0000_4599 issued, then a write to 0x0000_4567 arrives with rd_empty=1 → exactly 3 (T_RTW) cycles of TURN with cmd_valid=0, then wr_pop, then cmd_write=1, cmd_addr=0x0000_4567.
- Watermark: 6 writes queued, reads continuously available, last_dir=READ → switch to WR; writes drain until wr_count=2; then 4 idle cycles (T_WTR) and reads resume.
- Starvation: 3 writes queued, 20 reads queued → exactly 8 reads, then TURN(3), then write pops until the drain rule returns to reads.
- Backpressure: cmd_ready=0 for 5 cycles with 2 reads queued → slot holds the first address stable, no further pop; second pop occurs in the cycle cmd_ready=1 handshakes.

Source files
------------

// File: rtl/ddr5_ctrl_pkg.sv
// Shared types and default timing for the DDR5 controller datapath.
// Holds scheduler state encoding, direction codes and turnaround defaults.
package ddr5_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_TURN = 2'd3
    } sched_state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    localparam int T_WTR_DEF = 4;
    localparam int T_RTW_DEF = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr5_turnaround_timer.sv
// Loadable down-counter timing the bus-turnaround gap.
// done is high in the T-th cycle after the start cycle.
module ddr5_turnaround_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == CW'(1));

endmodule

// File: rtl/ddr5_rw_scheduler.sv
// Read/write command scheduler sharing the DDR5 command path between the
// write-request and read-address FIFOs, with turnaround gaps on direction change.
module ddr5_rw_scheduler
    import ddr5_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 4,
    parameter int WR_HI_WM   = 6,
    parameter int WR_LO_WM   = 2,
    parameter int T_WTR      = T_WTR_DEF,
    parameter int T_RTW      = T_RTW_DEF,
    parameter int STARVE_MAX = 8
) (
    input  logic              mem_clk,
    input  logic              rst_n,
    input  logic              wr_empty,
    input  logic [CNT_W-1:0]  wr_count,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_pop,
    input  logic              rd_empty,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_pop,
    output logic              cmd_valid,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_ready,
    output logic              busy
);

    localparam int TC_W = $clog2(max_int(T_WTR, T_RTW) + 1);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    sched_state_t    state;
    logic            last_dir;
    logic            commit;
    logic [SC_W-1:0] starve_cnt;

    logic            slot_free;
    logic            decide;
    logic            want_rd;
    logic            want_wr;
    logic            has_choice;
    logic            choice_dir;
    logic            load;
    logic            turn;
    logic            tmr_done;
    logic [TC_W-1:0] turn_len;

    assign slot_free = !cmd_valid || cmd_ready;
    assign decide    = rst_n && slot_free && (state != ST_TURN);

    // The cycle right after a turnaround forces the new direction instead of re-arbitrating.
    always_comb begin
        want_rd = 1'b0;
        want_wr = 1'b0;
        if (commit) begin
            want_rd = (last_dir == DIR_READ) && !rd_empty;
            want_wr = (last_dir == DIR_WRITE) && !wr_empty;
        end else if (last_dir == DIR_READ) begin
            if (!wr_empty && (wr_count >= CNT_W'(WR_HI_WM) || rd_empty ||
                              starve_cnt == SC_W'(STARVE_MAX))) begin
                want_wr = 1'b1;
            end else if (!rd_empty) begin
                want_rd = 1'b1;
            end
        end else begin
            if (!rd_empty && (wr_empty || wr_count <= CNT_W'(WR_LO_WM))) begin
                want_rd = 1'b1;
            end else if (!wr_empty) begin
                want_wr = 1'b1;
            end
        end
    end

    assign has_choice = want_rd || want_wr;
    assign choice_dir = want_wr ? DIR_WRITE : DIR_READ;
    assign load       = decide && has_choice && (choice_dir == last_dir);
    assign turn       = decide && has_choice && (choice_dir != last_dir);
    assign rd_pop     = load && (choice_dir == DIR_READ);
    assign wr_pop     = load && (choice_dir == DIR_WRITE);
    assign busy       = (state != ST_IDLE) || cmd_valid;
    assign turn_len   = (choice_dir == DIR_READ) ? TC_W'(T_WTR) : TC_W'(T_RTW);

    ddr5_turnaround_timer #(.CW(TC_W)) u_timer (
        .clk      (mem_clk),
        .rst_n    (rst_n),
        .start    (turn),
        .load_val (turn_len),
        .done     (tmr_done)
    );

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_dir   <= DIR_READ;
            commit     <= 1'b0;
            starve_cnt <= '0;
            cmd_valid  <= 1'b0;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
        end else begin
            commit <= 1'b0;
            if (state == ST_TURN) begin
                if (tmr_done) begin
                    state  <= (last_dir == DIR_WRITE) ? ST_WR : ST_RD;
                    commit <= 1'b1;
                end
            end else if (slot_free) begin
                if (load) begin
                    cmd_valid <= 1'b1;
                    cmd_write <= choice_dir;
                    cmd_addr  <= (choice_dir == DIR_WRITE) ? wr_addr : rd_addr;
                    state     <= (choice_dir == DIR_WRITE) ? ST_WR : ST_RD;
                end else begin
                    cmd_valid <= 1'b0;
                    state     <= turn ? ST_TURN : ST_IDLE;
                    if (turn) begin
                        last_dir <= choice_dir;
                    end
                end
            end

            if (wr_empty || wr_pop) begin
                starve_cnt <= '0;
            end else if (rd_pop && starve_cnt != SC_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

endmodule
